led_status_array: RTL and testbench
===================================

LED_STATUS_ARRAY -- requirements
Module: led_status_array

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, sets the clk frequency in Hz.
REQ-002 Parameter NUM_CH, default 4, sets the number of independent status channels; legal values are 1 to 32.
REQ-003 Parameter BLINK_HZ, default 1, sets the blink frequency; HALF_CNT = CLOCK_FREQ/(2*BLINK_HZ) - 1, and HALF_CNT SHALL be at least 1.
REQ-004 Parameter GAP_TICKS, default 4, sets the number of half-periods in the dark gap between code bursts; minimum 1.
REQ-005 clk  input  1  single system clock; all logic SHALL be rising-edge clocked.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 rw_done  input  NUM_CH  per-channel operation-complete level; bit i belongs to channel i.
REQ-008 rw_res  input  NUM_CH  per-channel result; 1 = pass, 0 = fail.
REQ-009 err_code  input  3*NUM_CH  per-channel fail code; bits [3i+2:3i] belong to channel i.
REQ-010 led  output  NUM_CH  registered LED drive; 1 = lit.

Function
REQ-011 A shared 32-bit prescaler SHALL count 0..HALF_CNT and wrap to 0; tick is high for exactly the one cycle in which the count equals HALF_CNT.
REQ-012 The prescaler SHALL free-run from reset release and SHALL NOT be restarted by any channel event.
REQ-013 Each rw_done bit SHALL be registered once (done_q) before use; rw_res and err_code SHALL be used unregistered.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, PASS, FAIL_ON, FAIL_OFF and GAP, plus a 3-bit latched code, a 3-bit pulse count and a gap count.
REQ-015 led[i] SHALL be registered and updated in the same cycle as the state: 1 in PASS and FAIL_ON, 0 in IDLE, FAIL_OFF and GAP.
REQ-016 done_q[i]=0 SHALL force IDLE on the next edge from any state; this has highest priority.
REQ-017 IDLE with done_q=1: rw_res=1 -> PASS; rw_res=0 -> FAIL_ON, latching err_code and clearing the pulse count.
REQ-018 PASS with rw_res=0 -> FAIL_ON with code latched and pulse count cleared. Any FAIL state with rw_res=1 -> PASS. These transitions SHALL NOT wait for tick.
REQ-019 FAIL_ON on tick -> FAIL_OFF, and the pulse count increments.
REQ-020 FAIL_OFF on tick:
- latched code 0 -> FAIL_ON (continuous 50% blink, legacy behaviour);
- pulse count < code -> FAIL_ON;
- otherwise -> GAP with the gap count cleared.
REQ-021 GAP on tick increments the gap count; a tick with gap count = GAP_TICKS-1 -> FAIL_ON, re-latching err_code and clearing the pulse count.
REQ-022 err_code changes SHALL take effect only at a latch point (REQ-017, REQ-018, REQ-021), never mid-burst.
REQ-023 Latency: a rw_done rise sampled at edge N gives done_q at N+1 and a led/state change at N+2; the same two-edge latency SHALL apply to a fall.
REQ-024 The first FAIL_ON phase after entry MAY last 1..HALF_CNT+1 cycles because tick is not phase-aligned; all later phases SHALL last exactly HALF_CNT+1 cycles.
REQ-025 Channels SHALL NOT interact except through the shared tick; simultaneous events on several channels SHALL each be handled in the same cycle.
REQ-026 A tick coinciding with a rw_res or rw_done transition SHALL resolve by priority REQ-016, then REQ-018, then the tick transitions.

Reset
REQ-027 While rst_n=0 at a rising edge, the following SHALL all clear: prescaler = 0, done_q = 0, every FSM = IDLE, all counts and latched codes = 0, led = 0.
REQ-028 Reset asserted mid-burst SHALL abort the sequence; after release, behaviour SHALL be identical to power-up.
REQ-029 No logic SHALL respond to rst_n except at a rising clk edge.

Verification
REQ-030 The bench SHALL use CLOCK_FREQ=20, BLINK_HZ=1 (HALF_CNT=9, phase = 10 cycles), GAP_TICKS=2, NUM_CH=2 unless stated, and SHALL cover:
- Pass: rw_done[0]=1, rw_res[0]=1 -> led[0]=1 two edges later and held; rw_done[0]=0 -> led[0]=0 two edges later.
- Legacy blink: done=1, res=0, code=0 -> led toggles every 10 cycles indefinitely after the first partial phase.
- Code burst: code=3 -> three 10-cycle on pulses separated by 10-cycle off phases, then 30 cycles dark (one off phase plus 2-tick gap), then repeat; changing code to 1 mid-burst takes effect only after the gap.
- Fail to pass: res rises during FAIL_OFF -> led=1 on the next edge without waiting for tick; res falls -> FAIL_ON immediately.
- Independence: channel 0 pass and channel 1 code=2 simultaneously -> correct patterns on both, with channel 1 edges aligned to the shared tick.
- Reset: rst_n=0 for 1 cycle mid-burst with rw_done held 1 -> led=0 and prescaler=0 at that edge; the burst restarts from pulse 1 at release+2.

Source files
------------

// File: rtl/led_status_array.sv
// Per-channel status LED driver: solid on for pass, blinked error code bursts for fail.
// A shared prescaler produces the half-period tick that paces every channel.
module led_status_array #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int NUM_CH     = 4,
    parameter int BLINK_HZ   = 1,
    parameter int GAP_TICKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     rw_done,
    input  logic [NUM_CH-1:0]     rw_res,
    input  logic [3*NUM_CH-1:0]   err_code,
    output logic [NUM_CH-1:0]     led,
    output logic [3*NUM_CH-1:0]   state_dbg
);

    localparam logic [31:0] HALF_CNT = 32'(CLOCK_FREQ / (2 * BLINK_HZ) - 1);
    localparam int          GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS     = 3'd1,
        FAIL_ON  = 3'd2,
        FAIL_OFF = 3'd3,
        GAP      = 3'd4
    } state_t;

    logic [31:0]       presc;
    logic              tick;
    logic [NUM_CH-1:0] done_q;

    assign tick = (presc == HALF_CNT);

    // Free-running; never restarted by channel activity so all channels share one phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            done_q <= '0;
        end else begin
            presc  <= tick ? '0 : presc + 32'd1;
            done_q <= rw_done;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t          st, st_n;
        logic [2:0]      code, code_n;
        logic [2:0]      pcnt, pcnt_n;
        logic [GW-1:0]   gcnt, gcnt_n;
        logic            led_q;
        logic [2:0]      code_in;

        assign code_in = err_code[3*i +: 3];

        always_comb begin
            st_n   = st;
            code_n = code;
            pcnt_n = pcnt;
            gcnt_n = gcnt;
            if (!done_q[i]) begin
                st_n = IDLE;
            end else begin
                case (st)
                    IDLE: begin
                        if (rw_res[i]) begin
                            st_n = PASS;
                        end else begin
                            st_n   = FAIL_ON;
                            code_n = code_in;
                            pcnt_n = 3'd0;
                        end
                    end
                    PASS: begin
                        if (!rw_res[i]) begin
                            st_n   = FAIL_ON;
                            code_n = code_in;
                            pcnt_n = 3'd0;
                        end
                    end
                    FAIL_ON: begin
                        if (rw_res[i]) begin
                            st_n = PASS;
                        end else if (tick) begin
                            st_n   = FAIL_OFF;
                            pcnt_n = pcnt + 3'd1;
                        end
                    end
                    FAIL_OFF: begin
                        if (rw_res[i]) begin
                            st_n = PASS;
                        end else if (tick) begin
                            // Code 0 keeps the legacy endless 50% blink.
                            if (code == 3'd0 || pcnt < code) begin
                                st_n = FAIL_ON;
                            end else begin
                                st_n   = GAP;
                                gcnt_n = '0;
                            end
                        end
                    end
                    GAP: begin
                        if (rw_res[i]) begin
                            st_n = PASS;
                        end else if (tick) begin
                            if (gcnt == GW'(GAP_TICKS - 1)) begin
                                st_n   = FAIL_ON;
                                code_n = code_in;
                                pcnt_n = 3'd0;
                            end else begin
                                gcnt_n = gcnt + GW'(1);
                            end
                        end
                    end
                    default: st_n = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st    <= IDLE;
                code  <= '0;
                pcnt  <= '0;
                gcnt  <= '0;
                led_q <= 1'b0;
            end else begin
                st    <= st_n;
                code  <= code_n;
                pcnt  <= pcnt_n;
                gcnt  <= gcnt_n;
                led_q <= (st_n == PASS) || (st_n == FAIL_ON);
            end
        end

        assign led[i]             = led_q;
        assign state_dbg[3*i +: 3] = st;
    end

endmodule

// File: tb/tb_led_status_array.sv
// Directed bench for led_status_array: pass, legacy blink, code bursts, fail/pass
// switching, two-channel independence and mid-burst reset.
module tb_led_status_array;

    localparam int NUM_CH = 2;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] rw_done;
    logic [NUM_CH-1:0] rw_res;
    logic [3*NUM_CH-1:0] err_code;
    logic [NUM_CH-1:0] led;
    logic [3*NUM_CH-1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    led_status_array #(
        .CLOCK_FREQ(20),
        .NUM_CH    (NUM_CH),
        .BLINK_HZ  (1),
        .GAP_TICKS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rw_done  (rw_done),
        .rw_res   (rw_res),
        .err_code (err_code),
        .led      (led),
        .state_dbg(state_dbg)
    );

    // Clock and reset-relative edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edge_n = 0;
        else        edge_n = edge_n + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait until the negedge following posedge n after reset release.
    task automatic goto(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rw_done  = '0;
        rw_res   = '0;
        err_code = '0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_presc", dut.presc, 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        rst_n = 1'b1;

        // Pass on channel 0
        goto(2);
        rw_done[0] = 1'b1; rw_res[0] = 1'b1;
        goto(3);  chk("pass_lat1", 32'(led), 32'h0);
        goto(4);  chk("pass_on", 32'(led), 32'h1);
        chk("pass_state", 32'(state_dbg[2:0]), 32'h1);
        goto(14); chk("pass_hold", 32'(led), 32'h1);
        rw_done[0] = 1'b0;
        goto(15); chk("pass_fall1", 32'(led), 32'h1);
        goto(16); chk("pass_off", 32'(led), 32'h0);

        // Legacy blink, code 0
        goto(19);
        rw_done[0] = 1'b1; rw_res[0] = 1'b0; err_code[2:0] = 3'd0;
        goto(20); chk("leg_lat1", 32'(led), 32'h0);
        goto(21); chk("leg_on0", 32'(led), 32'h1);
        goto(29); chk("leg_on0_end", 32'(led), 32'h1);
        goto(30); chk("leg_off1", 32'(led), 32'h0);
        goto(39); chk("leg_off1_end", 32'(led), 32'h0);
        goto(40); chk("leg_on2", 32'(led), 32'h1);
        goto(50); chk("leg_off3", 32'(led), 32'h0);
        goto(60); chk("leg_on4", 32'(led), 32'h1);
        goto(62);
        rw_done[0] = 1'b0;
        goto(64); chk("leg_idle", 32'(led), 32'h0);

        // Code 3 burst, code changed to 1 mid-burst
        goto(70);
        rw_done[0] = 1'b1; rw_res[0] = 1'b0; err_code[2:0] = 3'd3;
        goto(72);  chk("c3_p1_on", 32'(led), 32'h1);
        goto(79);  chk("c3_p1_end", 32'(led), 32'h1);
        goto(80);  chk("c3_off1", 32'(led), 32'h0);
        goto(90);  chk("c3_p2_on", 32'(led), 32'h1);
        goto(95);  err_code[2:0] = 3'd1;
        goto(100); chk("c3_off2", 32'(led), 32'h0);
        goto(110); chk("c3_p3_on", 32'(led), 32'h1);
        goto(120); chk("c3_off3", 32'(led), 32'h0);
        goto(130); chk("c3_gap", 32'(led), 32'h0);
        chk("c3_gap_state", 32'(state_dbg[2:0]), 32'h4);
        goto(149); chk("c3_gap_end", 32'(led), 32'h0);
        goto(150); chk("c1_p1_on", 32'(led), 32'h1);
        goto(160); chk("c1_off1", 32'(led), 32'h0);
        goto(170); chk("c1_gap", 32'(led), 32'h0);
        goto(189); chk("c1_gap_end", 32'(led), 32'h0);
        goto(190); chk("c1_p1_again", 32'(led), 32'h1);

        // Fail to pass and back, without waiting for tick
        goto(200); chk("fp_off", 32'(led), 32'h0);
        goto(203); rw_res[0] = 1'b1;
        goto(204); chk("fp_pass", 32'(led), 32'h1);
        chk("fp_pass_state", 32'(state_dbg[2:0]), 32'h1);
        goto(207); rw_res[0] = 1'b0; err_code[2:0] = 3'd2;
        goto(208); chk("pf_on_state", 32'(state_dbg[2:0]), 32'h2);
        goto(210); chk("pf_off1", 32'(led), 32'h0);
        goto(220); chk("pf_on2", 32'(led), 32'h1);
        goto(240); chk("pf_gap", 32'(led), 32'h0);
        goto(260); chk("pf_restart", 32'(led), 32'h1);
        goto(262); rw_done[0] = 1'b0;
        goto(264); chk("pf_idle", 32'(led), 32'h0);

        // Two channels: ch0 pass, ch1 code 2
        goto(272);
        rw_done = 2'b11; rw_res = 2'b01; err_code = 6'b010_000;
        goto(273); chk("ind_lat1", 32'(led), 32'h0);
        goto(274); chk("ind_both_on", 32'(led), 32'h3);
        goto(279); chk("ind_p1_end", 32'(led), 32'h3);
        goto(280); chk("ind_off1", 32'(led), 32'h1);
        goto(290); chk("ind_p2_on", 32'(led), 32'h3);
        goto(300); chk("ind_off2", 32'(led), 32'h1);
        goto(310); chk("ind_gap", 32'(led), 32'h1);
        goto(329); chk("ind_gap_end", 32'(led), 32'h1);
        goto(330); chk("ind_restart", 32'(led), 32'h3);

        // One-cycle reset mid-burst with rw_done held
        goto(335);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_presc", dut.presc, 32'h0);
        chk("mid_rst_state", 32'(state_dbg), 32'h0);
        rst_n = 1'b1;
        goto(1);  chk("rel_lat1", 32'(led), 32'h0);
        goto(2);  chk("rel_on", 32'(led), 32'h3);
        goto(9);  chk("rel_p1_end", 32'(led), 32'h3);
        goto(10); chk("rel_off1", 32'(led), 32'h1);
        goto(20); chk("rel_p2_on", 32'(led), 32'h3);
        goto(30); chk("rel_off2", 32'(led), 32'h1);
        goto(40); chk("rel_gap", 32'(led), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
